// File: rtl/instr_fetch_responder.sv
// Memory-side responder for the RI5CY instruction-fetch port.
// Instruction words pushed by the BFM are queued in a FIFO and returned to
// the core through the instr_req/instr_gnt/instr_rvalid handshake, after a
// programmable grant delay. When the FIFO is empty the responder either
// returns a NOP or withholds the grant. The address of the last grant and a
// count of granted fetches are kept for scoreboarding.
//
// Handshakes:
//   push side : a word transfers in any cycle where push_valid_i && push_ready_o.
//               push_ready_o is low when the FIFO is full or flush_i is high.
//   fetch side: the core holds instr_req_i until it sees instr_gnt_o; a grant
//               in cycle t yields exactly one instr_rvalid_o pulse in t+1.
//               Dropping instr_req_i before the grant sets the sticky err_o.
module instr_fetch_responder #(
    parameter int          DEPTH          = 8,
    parameter int          GNT_WAIT       = 0,
    parameter int          STALL_ON_EMPTY = 0,
    parameter logic [31:0] NOP_INSTR      = 32'h0000_0013
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       push_valid_i,
    output logic                       push_ready_o,
    input  logic [31:0]                push_data_i,
    input  logic                       instr_req_i,
    input  logic [31:0]                instr_addr_i,
    output logic                       instr_gnt_o,
    output logic                       instr_rvalid_o,
    output logic [31:0]                instr_rdata_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic [31:0]                last_addr_o,
    output logic [15:0]                fetch_count_o,
    output logic                       err_o
);

    localparam int             AW       = $clog2(DEPTH);
    localparam int             LW       = AW + 1;
    localparam logic [LW-1:0]  FULL_LVL = LW'(DEPTH);
    localparam logic [3:0]     GW       = 4'(GNT_WAIT);
    localparam bit             NO_WAIT  = (GNT_WAIT == 0);
    localparam bit             STALL    = (STALL_ON_EMPTY != 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READY = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            err_set;

    logic [31:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]   count_q;
    logic            has_data, full;
    logic            push, pop, eligible, gnt;

    assign has_data     = (count_q != '0);
    assign full         = (count_q == FULL_LVL);
    assign push_ready_o = !full && !flush_i;
    assign push         = push_valid_i && push_ready_o;
    assign pop          = gnt && has_data;
    assign level_o      = count_q;
    assign instr_gnt_o  = gnt;

    // Grant eligibility: cycle 0 in IDLE when there is no delay, the last
    // delay cycle in WAIT, or any cycle in READY (delay already expired).
    always_comb begin
        eligible = 1'b0;
        case (state_q)
            ST_IDLE:  eligible = NO_WAIT;
            ST_WAIT:  eligible = (cnt_q == GW);
            ST_READY: eligible = 1'b1;
            default:  eligible = 1'b0;
        endcase
        gnt = !flush_i && instr_req_i && eligible && (has_data || !STALL);
    end

    // Next-state logic for the grant FSM and the delay counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_set = 1'b0;
        if (flush_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (instr_req_i) begin
                        if (gnt) begin
                            state_d = ST_IDLE;
                        end else if (NO_WAIT) begin
                            state_d = ST_READY;
                        end else begin
                            state_d = ST_WAIT;
                            cnt_d   = 4'd1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!instr_req_i) begin
                        err_set = 1'b1;
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == GW) begin
                        state_d = gnt ? ST_IDLE : ST_READY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                ST_READY: begin
                    if (!instr_req_i) begin
                        err_set = 1'b1;
                        state_d = ST_IDLE;
                    end else if (gnt) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FIFO storage; contents need no reset since count_q gates every read.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_q] <= push_data_i;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Response path and scoreboarding state, updated on every grant.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            instr_rvalid_o <= 1'b0;
            instr_rdata_o  <= '0;
            last_addr_o    <= '0;
            fetch_count_o  <= '0;
            err_o          <= 1'b0;
        end else begin
            instr_rvalid_o <= gnt;
            if (gnt) begin
                instr_rdata_o <= has_data ? mem[rd_ptr_q] : NOP_INSTR;
                last_addr_o   <= instr_addr_i;
                fetch_count_o <= fetch_count_o + 16'd1;
            end
            if (err_set) begin
                err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_responder.sv
// Directed testbench for instr_fetch_responder. Three instances cover the
// parameter corners: a (no delay, NOP on empty), b (stall on empty) and
// c (grant delay of two cycles).
module tb_instr_fetch_responder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    // Instance a: GNT_WAIT=0, STALL_ON_EMPTY=0
    logic a_flush = 0, a_push_valid = 0, a_req = 0;
    logic [31:0] a_push_data = '0, a_addr = '0;
    logic a_push_ready, a_gnt, a_rvalid, a_err;
    logic [31:0] a_rdata, a_last_addr;
    logic [3:0]  a_level;
    logic [15:0] a_fetch_count;

    // Instance b: GNT_WAIT=0, STALL_ON_EMPTY=1
    logic b_flush = 0, b_push_valid = 0, b_req = 0;
    logic [31:0] b_push_data = '0, b_addr = '0;
    logic b_push_ready, b_gnt, b_rvalid, b_err;
    logic [31:0] b_rdata, b_last_addr;
    logic [3:0]  b_level;
    logic [15:0] b_fetch_count;

    // Instance c: GNT_WAIT=2, STALL_ON_EMPTY=0
    logic c_flush = 0, c_push_valid = 0, c_req = 0;
    logic [31:0] c_push_data = '0, c_addr = '0;
    logic c_push_ready, c_gnt, c_rvalid, c_err;
    logic [31:0] c_rdata, c_last_addr;
    logic [3:0]  c_level;
    logic [15:0] c_fetch_count;

    instr_fetch_responder #(.DEPTH(8), .GNT_WAIT(0), .STALL_ON_EMPTY(0)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(a_flush),
        .push_valid_i(a_push_valid), .push_ready_o(a_push_ready), .push_data_i(a_push_data),
        .instr_req_i(a_req), .instr_addr_i(a_addr), .instr_gnt_o(a_gnt),
        .instr_rvalid_o(a_rvalid), .instr_rdata_o(a_rdata), .level_o(a_level),
        .last_addr_o(a_last_addr), .fetch_count_o(a_fetch_count), .err_o(a_err)
    );

    instr_fetch_responder #(.DEPTH(8), .GNT_WAIT(0), .STALL_ON_EMPTY(1)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(b_flush),
        .push_valid_i(b_push_valid), .push_ready_o(b_push_ready), .push_data_i(b_push_data),
        .instr_req_i(b_req), .instr_addr_i(b_addr), .instr_gnt_o(b_gnt),
        .instr_rvalid_o(b_rvalid), .instr_rdata_o(b_rdata), .level_o(b_level),
        .last_addr_o(b_last_addr), .fetch_count_o(b_fetch_count), .err_o(b_err)
    );

    instr_fetch_responder #(.DEPTH(8), .GNT_WAIT(2), .STALL_ON_EMPTY(0)) dut_c (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(c_flush),
        .push_valid_i(c_push_valid), .push_ready_o(c_push_ready), .push_data_i(c_push_data),
        .instr_req_i(c_req), .instr_addr_i(c_addr), .instr_gnt_o(c_gnt),
        .instr_rvalid_o(c_rvalid), .instr_rdata_o(c_rdata), .level_o(c_level),
        .last_addr_o(c_last_addr), .fetch_count_o(c_fetch_count), .err_o(c_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] w [3];
        w[0] = 32'h000F_a103;
        w[1] = 32'h000F_a183;
        w[2] = 32'h0021_80B3;

        // ---------------- reset ----------------
        repeat (2) @(posedge clk);
        #1;
        check("rst_rvalid", 32'(a_rvalid), 32'd0);
        check("rst_rdata", a_rdata, 32'd0);
        check("rst_level", 32'(a_level), 32'd0);
        check("rst_fetch_count", 32'(a_fetch_count), 32'd0);
        check("rst_err", 32'(a_err), 32'd0);
        check("rst_last_addr", a_last_addr, 32'd0);
        check("rst_gnt", 32'(a_gnt), 32'd0);
        check("rst_push_ready", 32'(a_push_ready), 32'd1);
        a_flush = 1;
        #1;
        check("rst_push_ready_flush", 32'(a_push_ready), 32'd0);
        a_flush = 0;
        rst_n = 1;
        tick();

        // ---------------- three words, back-to-back grants ----------------
        for (int i = 0; i < 3; i++) begin
            a_push_valid = 1;
            a_push_data  = w[i];
            exp_q.push_back(w[i]);
            #1;
            check("t1_push_ready", 32'(a_push_ready), 32'd1);
            tick();
        end
        a_push_valid = 0;
        #1;
        check("t1_level_before", 32'(a_level), 32'd3);
        for (int c = 0; c < 4; c++) begin
            a_req = (c < 3);
            if (c < 3) a_addr = 32'h100 + 32'(4 * c);
            #1;
            check("t1_gnt", 32'(a_gnt), (c < 3) ? 32'd1 : 32'd0);
            if (c > 0) begin
                check("t1_rvalid", 32'(a_rvalid), 32'd1);
                check("t1_rdata", a_rdata, exp_q.pop_front());
            end
            tick();
        end
        #1;
        check("t1_rvalid_end", 32'(a_rvalid), 32'd0);
        check("t1_fetch_count", 32'(a_fetch_count), 32'd3);
        check("t1_level_after", 32'(a_level), 32'd0);
        check("t1_last_addr", a_last_addr, 32'h108);
        tick();

        // ---------------- empty FIFO returns NOP ----------------
        a_req  = 1;
        a_addr = 32'h80;
        #1;
        check("t2_gnt", 32'(a_gnt), 32'd1);
        tick();
        a_req = 0;
        #1;
        check("t2_rvalid", 32'(a_rvalid), 32'd1);
        check("t2_rdata_nop", a_rdata, 32'h0000_0013);
        check("t2_last_addr", a_last_addr, 32'h80);
        check("t2_fetch_count", 32'(a_fetch_count), 32'd4);
        tick();
        #1;
        check("t2_rvalid_one_cycle", 32'(a_rvalid), 32'd0);
        check("t2_rdata_hold", a_rdata, 32'h0000_0013);
        tick();

        // ---------------- fill to full, then one grant frees a slot ----------------
        for (int i = 0; i < 9; i++) begin
            a_push_valid = 1;
            a_push_data  = 32'h1000 + 32'(i);
            #1;
            check("t5_push_ready", 32'(a_push_ready), (i < 8) ? 32'd1 : 32'd0);
            if (i < 8) tick();
        end
        check("t5_level_full", 32'(a_level), 32'd8);
        a_req  = 1;
        a_addr = 32'h200;
        #1;
        check("t5_gnt", 32'(a_gnt), 32'd1);
        tick();
        a_req = 0;
        #1;
        check("t5_push_ready_after_pop", 32'(a_push_ready), 32'd1);
        check("t5_level_after_pop", 32'(a_level), 32'd7);
        check("t5_rvalid", 32'(a_rvalid), 32'd1);
        check("t5_rdata", a_rdata, 32'h1000);
        tick();
        a_push_valid = 0;
        #1;
        check("t5_level_ninth", 32'(a_level), 32'd8);

        // ---------------- flush behaviour ----------------
        a_flush = 1;
        a_req   = 1;
        a_addr  = 32'h2fc;
        #1;
        check("t6_push_ready_flush", 32'(a_push_ready), 32'd0);
        check("t6_no_gnt_in_flush", 32'(a_gnt), 32'd0);
        tick();
        a_flush = 0;
        a_req   = 0;
        #1;
        check("t6_level_flushed", 32'(a_level), 32'd0);
        check("t6_fetch_count", 32'(a_fetch_count), 32'd5);
        for (int i = 0; i < 3; i++) begin
            a_push_valid = 1;
            a_push_data  = 32'hA1 + 32'(i);
            tick();
        end
        a_push_valid = 0;
        #1;
        check("t6_level_3", 32'(a_level), 32'd3);
        a_req  = 1;
        a_addr = 32'h300;
        #1;
        check("t6_gnt", 32'(a_gnt), 32'd1);
        tick();
        a_req        = 0;
        a_flush      = 1;
        a_push_valid = 1;
        a_push_data  = 32'hBAD;
        #1;
        check("t6_push_ready_low", 32'(a_push_ready), 32'd0);
        check("t6_rvalid_delivered", 32'(a_rvalid), 32'd1);
        check("t6_rdata_delivered", a_rdata, 32'hA1);
        check("t6_level_pre_flush", 32'(a_level), 32'd2);
        tick();
        a_flush      = 0;
        a_push_valid = 0;
        #1;
        check("t6_level_after_flush", 32'(a_level), 32'd0);
        check("t6_rvalid_after_flush", 32'(a_rvalid), 32'd0);
        check("t6_rdata_hold", a_rdata, 32'hA1);
        check("t6_fetch_count_end", 32'(a_fetch_count), 32'd6);
        check("t6_last_addr", a_last_addr, 32'h300);
        check("t6_err", 32'(a_err), 32'd0);
        tick();

        // ---------------- stall on empty ----------------
        for (int c = 0; c < 6; c++) begin
            b_req        = 1;
            b_addr       = 32'h40;
            b_push_valid = (c == 5);
            b_push_data  = 32'h000F_a103;
            #1;
            check("t3_gnt_stalled", 32'(b_gnt), 32'd0);
            tick();
        end
        b_push_valid = 0;
        #1;
        check("t3_gnt", 32'(b_gnt), 32'd1);
        check("t3_level", 32'(b_level), 32'd1);
        tick();
        b_req = 0;
        #1;
        check("t3_rvalid", 32'(b_rvalid), 32'd1);
        check("t3_rdata", b_rdata, 32'h000F_a103);
        check("t3_fetch_count", 32'(b_fetch_count), 32'd1);
        check("t3_last_addr", b_last_addr, 32'h40);
        check("t3_err", 32'(b_err), 32'd0);
        check("t3_level_after", 32'(b_level), 32'd0);
        tick();

        // ---------------- grant delay of two cycles ----------------
        c_push_valid = 1;
        c_push_data  = 32'h0000_000A;
        tick();
        c_push_valid = 0;
        for (int c = 0; c < 4; c++) begin
            c_req  = (c < 3);
            c_addr = 32'h500;
            #1;
            check("t4_gnt", 32'(c_gnt), (c == 2) ? 32'd1 : 32'd0);
            if (c == 3) begin
                check("t4_rvalid", 32'(c_rvalid), 32'd1);
                check("t4_rdata", c_rdata, 32'h0000_000A);
                check("t4_fetch_count", 32'(c_fetch_count), 32'd1);
            end
            tick();
        end
        c_req = 1;
        #1;
        check("t4_req2_gnt_c0", 32'(c_gnt), 32'd0);
        tick();
        c_req = 0;
        #1;
        check("t4_req2_gnt_c1", 32'(c_gnt), 32'd0);
        check("t4_err_not_yet", 32'(c_err), 32'd0);
        tick();
        #1;
        check("t4_err_set", 32'(c_err), 32'd1);
        tick();
        tick();
        #1;
        check("t4_err_sticky", 32'(c_err), 32'd1);
        check("t4_no_extra_fetch", 32'(c_fetch_count), 32'd1);
        check("t4_no_rvalid", 32'(c_rvalid), 32'd0);

        // ---------------- asynchronous reset mid-WAIT ----------------
        c_req  = 1;
        c_addr = 32'h600;
        tick();
        #1;
        rst_n = 0;
        #1;
        check("t7_rvalid", 32'(c_rvalid), 32'd0);
        check("t7_rdata", c_rdata, 32'd0);
        check("t7_err", 32'(c_err), 32'd0);
        check("t7_last_addr", c_last_addr, 32'd0);
        check("t7_fetch_count", 32'(c_fetch_count), 32'd0);
        check("t7_level", 32'(c_level), 32'd0);
        check("t7_gnt", 32'(c_gnt), 32'd0);
        check("t7_push_ready", 32'(c_push_ready), 32'd1);
        c_req = 0;
        tick();
        rst_n = 1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_responder.md
Name: instr_fetch_responder

Overview:
- Memory-side responder on the RI5CY instruction-fetch port: answers instr_req/instr_gnt/instr_rvalid transactions with instruction words queued by the verification BFM.
- Sits between the BFM's send-instruction path (push side) and the core's fetch interface (core side).
- Holds words in a FIFO. Inserts a programmable grant delay. Either returns a NOP or stalls when empty. Logs fetch addresses and counts fetches for scoreboarding.

Parameters:
- DEPTH, 8: FIFO entries; power of two, at least 2.
- GNT_WAIT, 0: cycles from first sampled instr_req_i to instr_gnt_o; range 0..15.
- STALL_ON_EMPTY, 0: 1 = withhold grant while FIFO empty; 0 = grant and return NOP_INSTR.
- NOP_INSTR, 32'h00000013: word returned on an empty-FIFO grant (addi x0,x0,0).

Ports:
- clk_i  in  1  clock; all state on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  empties FIFO and returns FSM to IDLE.
- push_valid_i  in  1  BFM offers an instruction word.
- push_ready_o  out  1  FIFO can accept; equals !full && !flush_i.
- push_data_i  in  32  instruction word.
- instr_req_i  in  1  core fetch request.
- instr_addr_i  in  32  core fetch address.
- instr_gnt_o  out  1  request accepted this cycle (combinational from state).
- instr_rvalid_o  out  1  rdata valid; registered.
- instr_rdata_o  out  32  returned instruction; registered.
- level_o  out  $clog2(DEPTH)+1  FIFO occupancy.
- last_addr_o  out  32  instr_addr_i captured at the last grant.
- fetch_count_o  out  16  granted fetches; wraps 0xFFFF->0.
- err_o  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (async assert, sync release): FIFO empty, FSM IDLE, all outputs 0 except push_ready_o=!flush_i. instr_rdata_o=0.
- FIFO:
  - Push when push_valid_i && push_ready_o.
  - Pop on each grant when level_o>0.
  - Emptiness and fullness come from the registered count, so a word pushed in cycle t is poppable from t+1.
  - Push and pop in the same cycle leave level unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states:
  - IDLE: no request in progress.
  - WAIT: counting toward GNT_WAIT.
  - READY: delay expired, waiting for data (STALL_ON_EMPTY=1 only).
- Timing reference: the first cycle instr_req_i is high in IDLE is cycle 0. gnt is eligible in cycle GNT_WAIT. With GNT_WAIT=0, gnt may assert in cycle 0.
- Grant condition: eligible && (level_o>0 || STALL_ON_EMPTY==0).
  - If eligible but FIFO empty with STALL_ON_EMPTY=1, enter or stay in READY.
  - Grant as soon as level_o>0.
- After a grant, return to IDLE. If instr_req_i is still high next cycle, that cycle is a new cycle 0, so GNT_WAIT=0 gives back-to-back grants every cycle.
- On a grant in cycle t:
  - instr_rvalid_o=1 in t+1.
  - instr_rdata_o = popped word, or NOP_INSTR if the FIFO was empty.
  - last_addr_o <= instr_addr_i.
  - fetch_count_o increments.
- instr_rvalid_o is high for exactly one cycle per grant. instr_rdata_o holds its last value while rvalid is low.
- instr_req_i deasserting in WAIT or READY before a grant:
  - err_o <= 1 (sticky until reset).
  - FSM returns to IDLE.
  - No pop.
- flush_i:
  - Clears the FIFO and forces IDLE. A grant cannot occur in the flush cycle.
  - An rvalid already scheduled from the previous cycle's grant is still delivered.
  - Push in the flush cycle is discarded; push_ready_o is low.
- Reset mid-transaction drops any pending rvalid; instr_rvalid_o is 0 immediately.

Test Plan:
- GNT_WAIT=0: push 0x000Fa103, 0x000Fa183, 0x002180B3, then hold req high from cycle 0 -> gnt cycles 0-2; rvalid cycles 1-3 with the words in order; fetch_count_o=3; level_o=0.
- STALL_ON_EMPTY=0, empty FIFO, req at addr 0x80 -> gnt in cycle 0; rvalid cycle 1 with rdata 0x00000013; last_addr_o=0x80.
- STALL_ON_EMPTY=1, req held 5 cycles, push 0x000Fa103 in cycle 5 -> gnt low cycles 0-5, high cycle 6; rvalid cycle 7 with 0x000Fa103.
- GNT_WAIT=2, FIFO holding 0x0000000A, req from cycle 0 -> gnt cycle 2 only; rvalid cycle 3; req dropped in cycle 1 of a second request -> err_o=1 and stays 1.
- Push 9 words with DEPTH=8, no req -> push_ready_o low after the 8th push, level_o=8; one grant -> push_ready_o high next cycle and the 9th word is accepted.
- flush_i the cycle after a grant with 3 words queued -> that grant's rvalid still delivered; level_o=0 next cycle; rst_ni low mid-WAIT -> all outputs 0 asynchronously.
